// File: rtl/hole_sensor_conditioner.sv
// Hole sensor front end: 2-flop synchroniser, per-channel debounce, rising-edge
// event capture, and a lowest-index-first issue queue producing one-hot ball pulses.
module hole_sensor_conditioner #(
  parameter int N_HOLE    = 8,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_HOLE-1:0] sensor_raw,
  input  logic              game_active,
  output logic [N_HOLE-1:0] ball,
  output logic [N_HOLE-1:0] pending,
  output logic              overrun,
  output logic [N_HOLE-1:0] db_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_HOLE-1:0] sync_p0;
  logic [N_HOLE-1:0] sync_p1;
  logic [CNT_W-1:0]  cnt_p2 [N_HOLE];
  logic [CNT_W-1:0]  cnt_next [N_HOLE];
  logic [N_HOLE-1:0] db_next;
  logic [N_HOLE-1:0] rise;
  logic [N_HOLE-1:0] issue;
  logic [N_HOLE-1:0] pending_next;
  logic              lost;

  // Stage p0/p1: two-flop synchroniser on the asynchronous sensor lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sensor_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; the level only moves after DB_CYCLES consecutive mismatches
  always_comb begin
    db_next = db_level;
    rise    = '0;
    for (int i = 0; i < N_HOLE; i++) begin
      cnt_next[i] = '0;
      if (sync_p1[i] != db_level[i]) begin
        if (cnt_p2[i] == CNT_LAST) begin
          db_next[i] = sync_p1[i];
          rise[i]    = sync_p1[i];
        end else begin
          cnt_next[i] = cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= '0;
      for (int i = 0; i < N_HOLE; i++) cnt_p2[i] <= '0;
    end else begin
      db_level <= db_next;
      for (int i = 0; i < N_HOLE; i++) cnt_p2[i] <= cnt_next[i];
    end
  end

  // Stage p3: queue and issue; the lowest set pending bit is isolated with x & -x
  always_comb begin
    issue        = '0;
    pending_next = '0;
    lost         = 1'b0;
    if (game_active) begin
      issue        = pending & (~pending + 1'b1);
      pending_next = (pending & ~issue) | rise;
      lost         = |(rise & pending & ~issue);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ball    <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= pending_next;
      ball    <= issue;
      if (lost) overrun <= 1'b1;
    end
  end

  a_ball_onehot : assert property (@(posedge clk) disable iff (rst) $countones(ball) <= 1)
    else $error("ball has more than one bit set: %b", ball);

endmodule

// File: tb/tb_hole_sensor_conditioner.sv
// Directed bench for hole_sensor_conditioner: main instance with DB_CYCLES=4,
// plus a DB_CYCLES=2 instance fast enough to force a queue overrun.
module tb_hole_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sensor_raw;
  logic       game_active;
  logic [7:0] ball, pending, db_level;
  logic       overrun;

  logic [7:0] raw2;
  logic       ga2;
  logic [7:0] ball2, pending2, db_level2;
  logic       overrun2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hole_sensor_conditioner #(.N_HOLE(8), .DB_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .game_active(game_active),
    .ball(ball), .pending(pending), .overrun(overrun), .db_level(db_level)
  );

  hole_sensor_conditioner #(.N_HOLE(8), .DB_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sensor_raw(raw2), .game_active(ga2),
    .ball(ball2), .pending(pending2), .overrun(overrun2), .db_level(db_level2)
  );

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_tests++;
      if (ball !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_ball: got %h expected 00", ball);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sensor_raw = '0; game_active = 1'b1; raw2 = '0; ga2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({ball, pending, db_level, overrun} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ball=%h pending=%h db=%h ovr=%b expected all 0",
               ball, pending, db_level, overrun);
    end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_single_event;
    sensor_raw[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_tests++;
      if (ball !== ((k == 7) ? 8'h08 : 8'h00)) begin
        n_fail++;
        $display("FAIL single_ball k=%0d: got %h expected %h", k, ball, (k == 7) ? 8'h08 : 8'h00);
      end
      n_tests++;
      if (db_level[3] !== (k >= 6)) begin
        n_fail++;
        $display("FAIL single_db k=%0d: got %b expected %b", k, db_level[3], k >= 6);
      end
    end
    n_tests++;
    if (pending !== 8'h00 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got pending=%h ovr=%b expected 00/0", pending, overrun);
    end
    sensor_raw[3] = 1'b0;
    idle(12);
  endtask

  task automatic test_glitch;
    sensor_raw[5] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) sensor_raw[5] = 1'b0;
      n_tests++;
      if (db_level[5] !== 1'b0 || ball !== 8'h00) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got db5=%b ball=%h expected 0/00", k, db_level[5], ball);
      end
    end
  endtask

  task automatic test_contention;
    logic [7:0] exp_ball [10];
    logic [7:0] exp_pend [10];
    for (int k = 0; k < 10; k++) begin exp_ball[k] = 8'h00; exp_pend[k] = 8'h00; end
    exp_pend[6] = 8'h85;
    exp_ball[7] = 8'h01; exp_pend[7] = 8'h84;
    exp_ball[8] = 8'h04; exp_pend[8] = 8'h80;
    exp_ball[9] = 8'h80; exp_pend[9] = 8'h00;
    sensor_raw = 8'h85;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_tests++;
      if (ball !== exp_ball[k] || pending !== exp_pend[k]) begin
        n_fail++;
        $display("FAIL contention k=%0d: got ball=%h pending=%h expected %h/%h",
                 k, ball, pending, exp_ball[k], exp_pend[k]);
      end
    end
    idle(5);
    sensor_raw = 8'h00;
    idle(12);
  endtask

  task automatic test_game_gate;
    game_active = 1'b0;
    sensor_raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_tests++;
      if (ball !== 8'h00 || pending !== 8'h00) begin
        n_fail++;
        $display("FAIL gate_idle k=%0d: got ball=%h pending=%h expected 00/00", k, ball, pending);
      end
    end
    n_tests++;
    if (db_level[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_db: got %b expected 1", db_level[1]);
    end
    game_active = 1'b1;
    idle(10);
    sensor_raw[1] = 1'b0;
    idle(10);
    sensor_raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_tests++;
      if (ball !== ((k == 7) ? 8'h02 : 8'h00)) begin
        n_fail++;
        $display("FAIL gate_reraise k=%0d: got %h expected %h", k, ball, (k == 7) ? 8'h02 : 8'h00);
      end
    end
    sensor_raw[1] = 1'b0;
    idle(12);
  endtask

  task automatic test_overrun;
    int ph [5] = '{0, 1, 2, 3, 0};
    // With game inactive nothing queues, so repeated rises cannot be lost.
    game_active = 1'b0;
    for (int r = 0; r < 2; r++) begin
      sensor_raw[4] = 1'b1;
      repeat (8) @(negedge clk);
      sensor_raw[4] = 1'b0;
      repeat (8) @(negedge clk);
    end
    n_tests++;
    if (pending !== 8'h00 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL inactive_noqueue: got pending=%h ovr=%b expected 00/0", pending, overrun);
    end
    game_active = 1'b1;
    // Channels 0-3 keep the issuer busy so channel 4 rises again while still pending.
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n_tests++;
      if ($countones(ball2) > 1) begin
        n_fail++;
        $display("FAIL ovr_onehot t=%0d: got ball2=%h expected at most one bit", t, ball2);
      end
      for (int c = 0; c < 5; c++) raw2[c] = (t >= ph[c]) && (((t - ph[c]) % 4) < 2);
    end
    raw2 = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (overrun2 !== 1'b1) begin
        n_fail++;
        $display("FAIL overrun_sticky k=%0d: got %b expected 1", k, overrun2);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({overrun2, pending2, db_level2, ball2} !== 25'd0 || {overrun, pending, db_level, ball} !== 25'd0) begin
      n_fail++;
      $display("FAIL overrun_reset: got ovr2=%b pend2=%h db2=%h ball2=%h ovr=%b pend=%h expected all 0",
               overrun2, pending2, db_level2, ball2, overrun, pending);
    end
    idle(8);
  endtask

  task automatic test_reset_discard;
    sensor_raw[6] = 1'b1;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    n_tests++;
    if (pending !== 8'h40) begin
      n_fail++;
      $display("FAIL discard_queued: got pending=%h expected 40", pending);
    end
    rst = 1'b1;
    sensor_raw[6] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (ball !== 8'h00 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL discard_reset: got ball=%h pending=%h expected 00/00", ball, pending);
    end
    idle(10);
  endtask

  initial begin
    test_reset;
    test_single_event;
    test_glitch;
    test_contention;
    test_game_gate;
    test_overrun;
    test_reset_discard;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
